soc_rst_sequencer: RTL and testbench

SOC_RST_SEQUENCER -- requirements
Module: soc_rst_sequencer

---
 rtl/soc_rst_pkg.sv | 33 +++
 rtl/rst_seq_cnt.sv | 30 +++
 rtl/soc_rst_sequencer.sv | 135 +++++++++++++
 tb/tb_soc_rst_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/soc_rst_pkg.sv
// Shared FSM state type, cause-bit layout and default timing for the SoC reset sequencer.
package soc_rst_pkg;

    typedef enum logic [1:0] {
        HOLD_ALL = 2'd0,
        REL_PO   = 2'd1,
        RUN      = 2'd2,
        SYS_HOLD = 2'd3
    } rst_state_e;

    localparam int CAUSE_COLD   = 0;
    localparam int CAUSE_SYSREQ = 1;
    localparam int CAUSE_WDOG   = 2;
    localparam int CAUSE_LOCKUP = 3;

    localparam logic [3:0] COLD_CAUSE = 4'b0001 << CAUSE_COLD;

    localparam int DEF_HOLD_CYC    = 16;
    localparam int DEF_STAGGER_CYC = 8;

    // Bits recorded on a warm entry; the cold bit is never set from here.
    function automatic logic [3:0] warm_cause(input logic sysreq,
                                              input logic wdog,
                                              input logic lockup_req);
        logic [3:0] bits_s;
        bits_s               = 4'b0000;
        bits_s[CAUSE_SYSREQ] = sysreq;
        bits_s[CAUSE_WDOG]   = wdog;
        bits_s[CAUSE_LOCKUP] = lockup_req;
        return bits_s;
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Sequencing counter: clears on state entry, counts while enabled, flags the terminal count.
module rst_seq_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_r;

    // Count register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == term);

endmodule

// File: rtl/soc_rst_sequencer.sv
// Cold/warm reset sequencer: staggered PORESETn/HRESETn release, warm holds and sticky cause bits.
module soc_rst_sequencer
    import soc_rst_pkg::*;
#(
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int CNT_W       = 8
) (
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       SYSRESETREQ,
    input  logic       WDOGRES,
    input  logic       LOCKUP,
    input  logic       LOCKUP_RST_EN,
    input  logic       CAUSE_CLR,
    output logic       PORESETn,
    output logic       HRESETn,
    output logic [3:0] RST_CAUSE,
    output logic       SEQ_BUSY
);

    localparam int MAX_CYC = (32'sd1 <<< CNT_W) - 32'sd1;
    localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] STAGGER_TC = CNT_W'(STAGGER_CYC - 32'sd1);

    if ((HOLD_CYC < 32'sd1) || (HOLD_CYC > MAX_CYC) ||
        (STAGGER_CYC < 32'sd1) || (STAGGER_CYC > MAX_CYC)) begin : g_cfg_err
        $error("soc_rst_sequencer: HOLD_CYC/STAGGER_CYC outside 1..2^CNT_W-1");
    end

    rst_state_e       state_r;
    rst_state_e       next_state_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic [CNT_W-1:0] term_s;
    logic             tc_s;
    logic             lockup_req_s;
    logic             warm_req_s;
    logic             warm_entry_s;
    logic [3:0]       cause_next_s;
    logic             poresetn_r;
    logic             hresetn_r;
    logic             busy_r;
    logic [3:0]       cause_r;

    assign lockup_req_s = LOCKUP & LOCKUP_RST_EN;
    assign warm_req_s   = SYSRESETREQ | WDOGRES | lockup_req_s;
    assign warm_entry_s = (state_r == RUN) && warm_req_s;
    assign cnt_clr_s    = (next_state_s != state_r);

    rst_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (SYSCLK),
        .rst  (SYSRST),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .term (term_s),
        .tc   (tc_s)
    );

    // Next-state selection and counter control.
    always_comb begin
        next_state_s = state_r;
        cnt_en_s     = 1'b0;
        term_s       = HOLD_TC;
        case (state_r)
            HOLD_ALL: begin
                cnt_en_s = 1'b1;
                term_s   = HOLD_TC;
                if (tc_s) next_state_s = REL_PO;
                else      next_state_s = HOLD_ALL;
            end
            REL_PO: begin
                cnt_en_s = 1'b1;
                term_s   = STAGGER_TC;
                if (tc_s) next_state_s = RUN;
                else      next_state_s = REL_PO;
            end
            RUN: begin
                if (warm_req_s) next_state_s = SYS_HOLD;
                else            next_state_s = RUN;
            end
            SYS_HOLD: begin
                cnt_en_s = 1'b1;
                term_s   = HOLD_TC;
                if (tc_s) next_state_s = RUN;
                else      next_state_s = SYS_HOLD;
            end
            default: begin
                next_state_s = HOLD_ALL;
            end
        endcase
    end

    // Cause update; bits set by a warm entry win over a coincident clear.
    always_comb begin
        cause_next_s = cause_r;
        if (warm_entry_s) begin
            if (CAUSE_CLR) cause_next_s = warm_cause(SYSRESETREQ, WDOGRES, lockup_req_s);
            else           cause_next_s = cause_r | warm_cause(SYSRESETREQ, WDOGRES, lockup_req_s);
        end else if (CAUSE_CLR) begin
            cause_next_s = 4'b0000;
        end else begin
            cause_next_s = cause_r;
        end
    end

    // State register; SYSRST restarts the cold sequence.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) state_r <= HOLD_ALL;
        else        state_r <= next_state_s;
    end

    // Output registers decode the state one edge later, keeping pins flop-driven.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            poresetn_r <= 1'b0;
            hresetn_r  <= 1'b0;
            busy_r     <= 1'b1;
            cause_r    <= COLD_CAUSE;
        end else begin
            poresetn_r <= (state_r != HOLD_ALL);
            hresetn_r  <= (state_r == RUN);
            busy_r     <= (state_r != RUN);
            cause_r    <= cause_next_s;
        end
    end

    assign PORESETn  = poresetn_r;
    assign HRESETn   = hresetn_r;
    assign SEQ_BUSY  = busy_r;
    assign RST_CAUSE = cause_r;

endmodule

// File: tb/tb_soc_rst_sequencer.sv
// Scoreboard bench for soc_rst_sequencer with HOLD_CYC=16, STAGGER_CYC=8.
module tb_soc_rst_sequencer;

    logic       SYSCLK = 1'b0;
    logic       SYSRST;
    logic       SYSRESETREQ;
    logic       WDOGRES;
    logic       LOCKUP;
    logic       LOCKUP_RST_EN;
    logic       CAUSE_CLR;
    logic       PORESETn;
    logic       HRESETn;
    logic [3:0] RST_CAUSE;
    logic       SEQ_BUSY;

    int n_vec = 0;
    int n_bad = 0;

    // Expected {PORESETn, HRESETn, SEQ_BUSY, RST_CAUSE} per edge, with a tag.
    logic [6:0] exp_q[$];
    string      tag_q[$];

    // Timing model: k = edges since SYSRST was first sampled low, wl = warm-hold edges left.
    int         k = -1;
    int         wl = 0;
    logic [3:0] m_cause = 4'b0001;

    always #5 SYSCLK = ~SYSCLK;

    soc_rst_sequencer #(
        .HOLD_CYC    (16),
        .STAGGER_CYC (8),
        .CNT_W       (8)
    ) dut (
        .SYSCLK        (SYSCLK),
        .SYSRST        (SYSRST),
        .SYSRESETREQ   (SYSRESETREQ),
        .WDOGRES       (WDOGRES),
        .LOCKUP        (LOCKUP),
        .LOCKUP_RST_EN (LOCKUP_RST_EN),
        .CAUSE_CLR     (CAUSE_CLR),
        .PORESETn      (PORESETn),
        .HRESETn       (HRESETn),
        .RST_CAUSE     (RST_CAUSE),
        .SEQ_BUSY      (SEQ_BUSY)
    );

    task automatic check_vec(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got po/h/busy/cause=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic sreq, input logic wdog,
                        input logic lock, input logic len, input logic clr,
                        input string tag);
        logic       po;
        logic       h;
        logic [3:0] bits;
        logic [6:0] got;
        SYSRST        = rst;
        SYSRESETREQ   = sreq;
        WDOGRES       = wdog;
        LOCKUP        = lock;
        LOCKUP_RST_EN = len;
        CAUSE_CLR     = clr;
        if (rst) begin
            k       = -1;
            wl      = 0;
            m_cause = 4'b0001;
            po      = 1'b0;
            h       = 1'b0;
        end else begin
            if (k < 1000) k++;
            po = (k >= 16);
            h  = (k >= 24) && (wl == 0);
            if (wl > 0) wl--;
            bits = {lock & len, wdog, sreq, 1'b0};
            if (h && (bits != 4'b0000)) begin
                wl      = 16;
                m_cause = (clr ? 4'b0000 : m_cause) | bits;
            end else if (clr) begin
                m_cause = 4'b0000;
            end
        end
        exp_q.push_back({po, h, ~h, m_cause});
        tag_q.push_back(tag);
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        got = {PORESETn, HRESETn, SEQ_BUSY, RST_CAUSE};
        check_vec(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    initial begin
        SYSRST        = 1'b1;
        SYSRESETREQ   = 1'b0;
        WDOGRES       = 1'b0;
        LOCKUP        = 1'b0;
        LOCKUP_RST_EN = 1'b0;
        CAUSE_CLR     = 1'b0;
        @(negedge SYSCLK);

        repeat (5)  step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cold_rst");
        repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cold_seq");

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wdog_pulse");
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "wdog_hold");

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "clr_alone");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "sysreq_lockup");
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "multi_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "clr_again");
        repeat (5)  step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lockup_no_en");

        repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "sysreq_held");
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_held");

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_pulse");
        repeat (18) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "to_rel_po");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_in_rel_po");
        repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cold_after_po");

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wdog_again");
        repeat (5)  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "in_sys_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_in_sys_hold");
        repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cold_after_sh");

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "clr_collide");
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "collide_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
